// File: rtl/serial_multrom_scheduler_pkg.sv
// Shared definitions for the serial ROM multiplier scheduler.
//
// Contents:
//   state_e            - scheduler FSM state encoding
//   DefaultCoreLatency - default start-to-product latency of the multiplier core
//   lat_cnt_width()    - width of the latency counter for a given core latency

package serial_multrom_scheduler_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StHold  = 2'd3
  } state_e;

  localparam int unsigned DefaultCoreLatency = 8;

  // One spare bit above ceil(log2(latency)) so the counter can hold the
  // latency value itself without wrapping.
  function automatic int unsigned lat_cnt_width(input int unsigned latency);
    return $clog2(latency) + 1;
  endfunction

endpackage

// File: rtl/serial_multrom_req_fifo.sv
// Request FIFO for the serial ROM multiplier scheduler.
//
// Ports:
//   clk      - clock, rising edge
//   rst_n    - asynchronous active-low reset (empties the FIFO, pointers to 0)
//   push_i   - write wdata_i; ignored when full (no bypass, even with pop)
//   wdata_i  - write data
//   pop_i    - discard the head entry; ignored when empty
//   rdata_o  - head entry (valid while empty_o is low)
//   full_o   - Depth entries stored
//   empty_o  - no entries stored

module serial_multrom_req_fifo #(
  parameter int unsigned Width = 16,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [PtrW:0]    count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == DepthCnt);
  assign empty_o = (count_q == '0);
  assign rdata_o = mem_q[rptr_q];

  // Full is evaluated before this cycle's pop, so a push into a full FIFO is
  // dropped even when the head leaves in the same cycle.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    // Depth is a power of two, so the pointers wrap naturally.
    if (push_ok) wptr_d = wptr_q + PtrW'(1);
    if (pop_ok)  rptr_d = rptr_q + PtrW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (PtrW + 1)'(1);
      2'b01:   count_d = count_q - (PtrW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/serial_multrom_scheduler.sv
// Scheduler in front of a serial ROM multiplier core.
//
// Requests (operand pairs) are queued in a FIFO and issued to the core one at
// a time. After CORE_LATENCY cycles the core accumulator is captured and held
// on the output until the consumer accepts it; only then is the next request
// issued, so results come out in acceptance order with one multiply in flight.
//
// Ports:
//   clk, rst_n               - clock (rising edge), async active-low reset
//   in_valid/in_ready        - request handshake; in_ready = FIFO not full
//   in_mult1/in_mult2        - request operands, 2*HALF_WIDTH bits
//   core_mult1/core_mult2    - registered operands to the core
//   core_start               - one-cycle start pulse to the core
//   core_dout                - core accumulator, 4*HALF_WIDTH bits
//   out_valid/out_ready      - result handshake
//   out_product              - captured product, 4*HALF_WIDTH bits

module serial_multrom_scheduler
  import serial_multrom_scheduler_pkg::*;
#(
  parameter int unsigned HALF_WIDTH   = 4,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned CORE_LATENCY = DefaultCoreLatency
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2*HALF_WIDTH-1:0] in_mult1,
  input  logic [2*HALF_WIDTH-1:0] in_mult2,
  output logic [2*HALF_WIDTH-1:0] core_mult1,
  output logic [2*HALF_WIDTH-1:0] core_mult2,
  output logic                    core_start,
  input  logic [4*HALF_WIDTH-1:0] core_dout,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [4*HALF_WIDTH-1:0] out_product
);

  localparam int unsigned OpW  = 2 * HALF_WIDTH;
  localparam int unsigned ProdW = 4 * HALF_WIDTH;
  localparam int unsigned CntW = lat_cnt_width(CORE_LATENCY);
  localparam logic [CntW-1:0] CntLast = CntW'(CORE_LATENCY - 1);

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [OpW-1:0]   mult1_q, mult1_d;
  logic [OpW-1:0]   mult2_q, mult2_d;
  logic             start_q, start_d;
  logic [ProdW-1:0] prod_q, prod_d;
  logic             valid_q, valid_d;

  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [ProdW-1:0] fifo_rdata;

  // Operands travel through the FIFO concatenated as {mult1, mult2}.
  serial_multrom_req_fifo #(
    .Width (ProdW),
    .Depth (FIFO_DEPTH)
  ) u_req_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (in_valid),
    .wdata_i ({in_mult1, in_mult2}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mult1_d  = mult1_q;
    mult2_d  = mult2_q;
    start_d  = 1'b0;
    prod_d   = prod_q;
    valid_d  = valid_q;
    fifo_pop = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) state_d = StIssue;
      end

      StIssue: begin
        // Only reached with a non-empty FIFO; the operands stay registered
        // until the next issue so the core sees them for the whole multiply.
        fifo_pop = 1'b1;
        mult1_d  = fifo_rdata[ProdW-1:OpW];
        mult2_d  = fifo_rdata[OpW-1:0];
        start_d  = 1'b1;
        cnt_d    = '0;
        state_d  = StWait;
      end

      StWait: begin
        // Counter is 0 in the start-pulse cycle, so it reaches CntLast in the
        // cycle the core presents its final product.
        if (cnt_q == CntLast) begin
          prod_d  = core_dout;
          valid_d = 1'b1;
          state_d = StHold;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StHold: begin
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = fifo_empty ? StIdle : StIssue;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      mult1_q <= '0;
      mult2_q <= '0;
      start_q <= 1'b0;
      prod_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mult1_q <= mult1_d;
      mult2_q <= mult2_d;
      start_q <= start_d;
      prod_q  <= prod_d;
      valid_q <= valid_d;
    end
  end

  assign in_ready    = !fifo_full;
  assign core_mult1  = mult1_q;
  assign core_mult2  = mult2_q;
  assign core_start  = start_q;
  assign out_valid   = valid_q;
  assign out_product = prod_q;

endmodule

// File: tb/tb_serial_multrom_scheduler.sv
// Self-checking bench for serial_multrom_scheduler with a behavioural core.

module tb_serial_multrom_scheduler;

  localparam int unsigned HW    = 4;
  localparam int unsigned OW    = 2 * HW;
  localparam int unsigned PW    = 4 * HW;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LAT   = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [OW-1:0] in_mult1 = '0;
  logic [OW-1:0] in_mult2 = '0;
  logic [OW-1:0] core_mult1;
  logic [OW-1:0] core_mult2;
  logic          core_start;
  logic [PW-1:0] core_dout = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [PW-1:0] out_product;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  serial_multrom_scheduler #(
    .HALF_WIDTH   (HW),
    .FIFO_DEPTH   (DEPTH),
    .CORE_LATENCY (LAT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_mult1    (in_mult1),
    .in_mult2    (in_mult2),
    .core_mult1  (core_mult1),
    .core_mult2  (core_mult2),
    .core_start  (core_start),
    .core_dout   (core_dout),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_product (out_product)
  );

  // Behavioural core: garbage while accumulating, the true product from the
  // LAT-th cycle counting the start cycle as the first.
  logic [OW-1:0] core_a = '0;
  logic [OW-1:0] core_b = '0;
  int            core_cnt = 0;

  always @(posedge clk) begin
    if (core_start) begin
      core_a    <= core_mult1;
      core_b    <= core_mult2;
      core_cnt  <= 1;
      core_dout <= 16'hDEAD;
    end else if (core_cnt != 0 && core_cnt < int'(LAT) - 1) begin
      core_cnt <= core_cnt + 1;
      if (core_cnt == int'(LAT) - 2) core_dout <= PW'(core_a) * PW'(core_b);
      else core_dout <= core_dout ^ 16'h0101;
    end
  end

  // Monitor and scoreboard producer.
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] got_q[$];
  int   cyc = 0;
  int   n_start = 0;
  int   outstanding = 0;
  int   overlap_err = 0;
  int   acc_cyc = 0;
  int   start_cyc = 0;
  int   hs_cyc = 0;
  int   gap_at_start = 0;
  int   lat_meas = 0;
  logic valid_prev = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      outstanding = 0;
      valid_prev  = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        exp_q.push_back(PW'(in_mult1) * PW'(in_mult2));
        acc_cyc = cyc;
      end
      if (core_start) begin
        n_start++;
        if (outstanding != 0) overlap_err++;
        outstanding++;
        start_cyc    = cyc;
        gap_at_start = cyc - hs_cyc;
      end
      if (out_valid && !valid_prev) lat_meas = cyc - start_cyc;
      if (out_valid && out_ready) begin
        hs_cyc = cyc;
        outstanding--;
      end
      valid_prev = out_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request and returns after the edge that accepts it, leaving
  // in_valid high so consecutive calls are back to back.
  task automatic send(input logic [OW-1:0] a, input logic [OW-1:0] b);
    logic ok;
    in_valid = 1'b1;
    in_mult1 = a;
    in_mult2 = b;
    for (int c = 0; ; c++) begin
      if (c >= 300) begin
        n_cmp++;
        n_fail++;
        $display("FAIL send_timeout: %0d x %0d not accepted, in_ready=%b required 1", a, b,
                 in_ready);
        in_valid = 1'b0;
        return;
      end
      ok = in_ready;
      tick();
      if (ok) break;
    end
  endtask

  task automatic wait_valid();
    for (int c = 0; c < 200; c++) begin
      if (out_valid) return;
      tick();
    end
    n_cmp++;
    n_fail++;
    $display("FAIL wait_valid_timeout: out_valid=%b required 1", out_valid);
  endtask

  // Consumes n results with out_ready high, checking each against the queue.
  task automatic collect(input int n);
    int got = 0;
    logic [PW-1:0] exp;
    out_ready = 1'b1;
    for (int c = 0; c < 100 * n && got < n; c++) begin
      if (out_valid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_result: got %0d, required no result", out_product);
        end else begin
          exp = exp_q.pop_front();
          if (out_product !== exp) begin
            n_fail++;
            $display("FAIL result_order: got %0d, required %0d", out_product, exp);
          end
        end
        got_q.push_back(out_product);
        got++;
      end
      tick();
    end
    if (got < n) begin
      n_cmp++;
      n_fail++;
      $display("FAIL collect_timeout: got %0d results, required %0d", got, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b, required 0", out_valid);
    end
    n_cmp++;
    if (out_product !== '0) begin
      n_fail++; $display("FAIL reset_out_product: got %0d, required 0", out_product);
    end
    n_cmp++;
    if (core_start !== 1'b0) begin
      n_fail++; $display("FAIL reset_core_start: got %b, required 0", core_start);
    end
    n_cmp++;
    if (core_mult1 !== '0 || core_mult2 !== '0) begin
      n_fail++;
      $display("FAIL reset_core_mult: got %0d/%0d, required 0/0", core_mult1, core_mult2);
    end
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
  endtask

  task automatic test_single();
    int s0 = n_start;
    got_q.delete();
    out_ready = 1'b1;
    send(13, 11);
    in_valid = 1'b0;
    collect(1);
    n_cmp++;
    if (got_q.size() != 1 || got_q[0] !== 16'd143) begin
      n_fail++; $display("FAIL single_product: got %0d, required 143", got_q[0]);
    end
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_valid_width: out_valid=%b after handshake, required 0",
                         out_valid);
    end
    n_cmp++;
    if (n_start - s0 != 1) begin
      n_fail++; $display("FAIL single_start_count: got %0d pulses, required 1", n_start - s0);
    end
    n_cmp++;
    if (start_cyc - acc_cyc != 3) begin
      n_fail++; $display("FAIL accept_to_start: got %0d cycles, required 3",
                         start_cyc - acc_cyc);
    end
    n_cmp++;
    if (lat_meas != int'(LAT)) begin
      n_fail++; $display("FAIL start_to_valid: got %0d cycles, required %0d", lat_meas, LAT);
    end
  endtask

  task automatic test_max();
    got_q.delete();
    send(255, 255);
    in_valid = 1'b0;
    collect(1);
    n_cmp++;
    if (got_q.size() != 1 || got_q[0] !== 16'd65025) begin
      n_fail++; $display("FAIL max_product: got %0d, required 65025", got_q[0]);
    end
  endtask

  task automatic test_back_to_back();
    int unsigned exp_vals[5] = '{1, 6, 20, 42, 72};
    got_q.delete();
    out_ready = 1'b0;
    send(1, 1);
    send(2, 3);
    send(4, 5);
    send(6, 7);
    send(8, 9);
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL b2b_full: in_ready=%b with 4 queued, required 0", in_ready);
    end
    // Keep offering a sixth request; none may be accepted while full.
    in_mult1 = 9;
    in_mult2 = 9;
    repeat (5) tick();
    in_valid = 1'b0;
    n_cmp++;
    if (exp_q.size() != 5) begin
      n_fail++; $display("FAIL b2b_accepted: got %0d accepted, required 5", exp_q.size());
    end
    collect(5);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (got_q.size() <= i || got_q[i] !== PW'(exp_vals[i])) begin
        n_fail++; $display("FAIL b2b_product_%0d: got %0d, required %0d", i, got_q[i],
                           exp_vals[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int s0;
    int bad = 0;
    got_q.delete();
    out_ready = 1'b0;
    send(7, 9);
    send(2, 2);
    in_valid = 1'b0;
    wait_valid();
    s0 = n_start;
    repeat (20) begin
      if (out_valid !== 1'b1 || out_product !== 16'd63) bad++;
      tick();
    end
    n_cmp++;
    if (bad != 0) begin
      n_fail++; $display("FAIL bp_stable: got %0d unstable cycles, required 0", bad);
    end
    n_cmp++;
    if (n_start != s0) begin
      n_fail++; $display("FAIL bp_no_start: got %0d pulses, required 0", n_start - s0);
    end
    collect(2);
    n_cmp++;
    if (got_q.size() != 2 || got_q[0] !== 16'd63 || got_q[1] !== 16'd4) begin
      n_fail++; $display("FAIL bp_products: got %0d,%0d, required 63,4", got_q[0], got_q[1]);
    end
    n_cmp++;
    if (gap_at_start != 2) begin
      n_fail++; $display("FAIL bp_issue_gap: got %0d cycles handshake-to-start, required 2",
                         gap_at_start);
    end
  endtask

  task automatic test_reset_mid_wait();
    int s0 = n_start;
    int s1;
    got_q.delete();
    out_ready = 1'b1;
    send(5, 5);
    send(6, 6);
    send(7, 7);
    in_valid = 1'b0;
    for (int c = 0; c < 50 && n_start == s0; c++) tick();
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || core_start !== 1'b0) begin
      n_fail++; $display("FAIL rst_wait_outputs: out_valid=%b core_start=%b, required 0/0",
                         out_valid, core_start);
    end
    n_cmp++;
    if (core_mult1 !== '0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_wait_state: core_mult1=%0d in_ready=%b, required 0/1",
                         core_mult1, in_ready);
    end
    exp_q.delete();
    s1 = n_start;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (30) tick();
    n_cmp++;
    if (n_start != s1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_wait_discard: got %0d pulses out_valid=%b, required 0/0",
                         n_start - s1, out_valid);
    end
    send(3, 3);
    in_valid = 1'b0;
    collect(1);
    n_cmp++;
    if (got_q.size() != 1 || got_q[0] !== 16'd9) begin
      n_fail++; $display("FAIL rst_wait_after: got %0d, required 9", got_q[0]);
    end
  endtask

  task automatic test_push_pop();
    int unsigned exp_vals[5] = '{12, 30, 56, 90, 132};
    logic [PW-1:0] exp;
    got_q.delete();
    out_ready = 1'b0;
    send(1, 2);
    in_valid = 1'b0;
    wait_valid();
    send(3, 4);
    send(5, 6);
    send(7, 8);
    in_valid = 1'b0;
    // Three queued, one result held: release it so the next cycle is ISSUE.
    out_ready = 1'b1;
    exp = exp_q.pop_front();
    n_cmp++;
    if (out_valid !== 1'b1 || out_product !== exp) begin
      n_fail++; $display("FAIL pp_held: got %0d valid=%b, required %0d valid=1", out_product,
                         out_valid, exp);
    end
    tick();
    in_valid = 1'b1;
    in_mult1 = 9;
    in_mult2 = 10;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL pp_ready_at_3: got %b, required 1", in_ready);
    end
    tick();
    // Push and pop together: occupancy stays 3, so exactly one more fits.
    in_mult1 = 11;
    in_mult2 = 12;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL pp_ready_after: got %b, required 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL pp_full_at_4: got %b, required 0", in_ready);
    end
    collect(5);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (got_q.size() <= i || got_q[i] !== PW'(exp_vals[i])) begin
        n_fail++; $display("FAIL pp_product_%0d: got %0d, required %0d", i, got_q[i],
                           exp_vals[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_max();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_wait();
    test_push_pop();
    repeat (20) tick();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL leftover_results: got %0d pending, required 0", exp_q.size());
    end
    n_cmp++;
    if (overlap_err != 0) begin
      n_fail++; $display("FAIL single_in_flight: got %0d overlapping starts, required 0",
                         overlap_err);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
